// File: rtl/tl_a_channel_queue.sv
// ---------------------------------------------------------------------------
// tl_a_channel_queue
//
// Registered FIFO for one TileLink-UL A channel (Get / PutFullData /
// PutPartialData).
//
// The queue sits in front of a pass-through port-routing shell. It retimes the
// A channel and isolates backpressure between the bus master and the slave.
// enq_ready depends only on occupancy, never combinationally on deq_ready.
// Requests leave in arrival order. No beat is dropped or duplicated.
//
// Configuration macro: TL_A_QUEUE_FLOW_EN
//   undefined : strictly registered. A beat accepted in cycle N appears on
//               deq_* in cycle N+1.
//   defined   : flow-through when empty. A beat offered to an empty queue is
//               presented on deq_* in the same cycle. If deq_ready is also
//               high, the beat passes straight through and is not stored.
//
// Parameters
//   DEPTH   entries, power of two, 2..8
//   ADDR_W  address width
//   DATA_W  data width (MASK_W = DATA_W/8)
//   SRC_W   source id width
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enq_valid/ready     upstream handshake
//   enq_* fields        opcode, param, size, source, address, mask, data
//   deq_valid/ready     downstream handshake
//   deq_* fields        head entry fields
//   count               occupancy, 0..DEPTH
//
// Handshake: a beat transfers on a port in any cycle where valid & ready are
// both high at the rising clock edge. A producer holding valid high must keep
// its fields stable until the beat transfers. valid never waits on ready.
// ---------------------------------------------------------------------------
module tl_a_channel_queue #(
  parameter  int DEPTH  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int SRC_W  = 4,
  localparam int MASK_W = DATA_W / 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [2:0]        enq_opcode,
  input  logic [2:0]        enq_param,
  input  logic [2:0]        enq_size,
  input  logic [SRC_W-1:0]  enq_source,
  input  logic [ADDR_W-1:0] enq_address,
  input  logic [MASK_W-1:0] enq_mask,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [2:0]        deq_opcode,
  output logic [2:0]        deq_param,
  output logic [2:0]        deq_size,
  output logic [SRC_W-1:0]  deq_source,
  output logic [ADDR_W-1:0] deq_address,
  output logic [MASK_W-1:0] deq_mask,
  output logic [DATA_W-1:0] deq_data,
  output logic [CNT_W-1:0]  count
);

  localparam int ENTRY_W = 9 + SRC_W + ADDR_W + MASK_W + DATA_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               r_maybe_full;
  logic [CNT_W-1:0]   r_count;

  logic               w_ptr_match;
  logic               w_empty;
  logic               w_full;
  logic               w_enq_fire;
  logic               w_deq_fire;
  logic               w_flow;
  logic               w_do_write;
  logic               w_do_read;
  logic [ENTRY_W-1:0] w_enq_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_enq_entry = {enq_opcode, enq_param, enq_size, enq_source,
                        enq_address, enq_mask, enq_data};

  // Equal pointers mean either empty or full. maybe_full records which one:
  // it is set when the last occupancy change was a write.
  assign w_ptr_match = (r_wr_ptr == r_rd_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match &  r_maybe_full;

  assign enq_ready  = ~w_full;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_deq_fire = deq_valid & deq_ready;

`ifdef TL_A_QUEUE_FLOW_EN
  // When empty, the incoming beat is shown directly on the output. If it is
  // taken in the same cycle, neither the storage nor the pointers change.
  assign w_flow    = w_empty & enq_valid & deq_ready;
  assign deq_valid = enq_valid | ~w_empty;
  assign w_head    = w_empty ? w_enq_entry : r_mem[r_rd_ptr];
`else
  assign w_flow    = 1'b0;
  assign deq_valid = ~w_empty;
  assign w_head    = r_mem[r_rd_ptr];
`endif

  assign w_do_write = w_enq_fire & ~w_flow;
  assign w_do_read  = w_deq_fire & ~w_flow;

  assign {deq_opcode, deq_param, deq_size, deq_source,
          deq_address, deq_mask, deq_data} = w_head;

  assign count = r_count;

  // Payload storage is not reset. Its contents are only visible while
  // deq_valid is high.
  always_ff @(posedge clock) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= w_enq_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_maybe_full <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_do_write) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_read) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      // A simultaneous write and read leaves occupancy unchanged.
      if (w_do_write != w_do_read) begin
        r_maybe_full <= w_do_write;
      end
      if (w_do_write && !w_do_read) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_read && !w_do_write) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
